// File: rtl/conv_map_writer_if.sv
// Pixel-stream, configuration, status and map-read signals between a conv
// pixel producer / map consumer (master) and conv_map_writer (slave).
interface conv_map_writer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = 10
);
  logic              start;
  logic [15:0]       imgSize;
  logic [15:0]       filterSize;
  logic              in_valid;
  logic [DATA_W-1:0] in_pixel;
  logic              in_ready;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [15:0]       out_size;
  logic [AW:0]       count;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic              overrun;

  modport master (
    output start, imgSize, filterSize, in_valid, in_pixel, rd_addr,
    input  in_ready, rd_data, out_size, count, busy, done, cfg_err, overrun
  );

  modport slave (
    input  start, imgSize, filterSize, in_valid, in_pixel, rd_addr,
    output in_ready, rd_data, out_size, count, busy, done, cfg_err, overrun
  );
endinterface

// File: rtl/conv_map_writer.sv
// Collects a raster-ordered stream of convolved pixels into an output feature
// map buffer and serves it through a registered read port.
module conv_map_writer #(
  parameter int unsigned MAX_N  = 32,
  parameter int unsigned DATA_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  conv_map_writer_if.slave   bus
);
  localparam int unsigned DEPTH = MAX_N * MAX_N;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned SW    = 16;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t            r_state, w_next_state;
  logic [SW-1:0]     r_out_size, r_row, r_col;
  logic [AW-1:0]     r_addr;
  logic [CW-1:0]     r_count;
  logic              r_done, r_cfg_err, r_overrun;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_ready, w_accept, w_last, w_legal, w_col_wrap;
  logic [SW-1:0]     w_new_size;

  // Next state and decode; start overrides everything, including an accept.
  always_comb begin
    w_next_state = r_state;
    w_ready      = (r_state == S_COLLECT);
    w_accept     = bus.in_valid && w_ready && !bus.start;
    w_new_size   = bus.imgSize - {bus.filterSize[SW-1:1], 1'b0};
    w_legal      = ((bus.filterSize == SW'(1)) || (bus.filterSize == SW'(3)) ||
                    (bus.filterSize == SW'(5))) &&
                   (bus.imgSize <= SW'(MAX_N)) && (bus.imgSize >= bus.filterSize);
    w_col_wrap   = (r_col == r_out_size - SW'(1));
    w_last       = w_accept && w_col_wrap && (r_row == r_out_size - SW'(1));
    if (bus.start) begin
      w_next_state = w_legal ? S_COLLECT : S_DONE;
    end else if (w_last) begin
      w_next_state = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Map position counters, config latch and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_size <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_addr     <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.start) begin
        r_out_size <= w_new_size;
        r_row      <= '0;
        r_col      <= '0;
        r_addr     <= '0;
        r_count    <= '0;
        r_overrun  <= 1'b0;
        r_cfg_err  <= !w_legal;
        r_done     <= !w_legal;
      end else begin
        if (w_accept) begin
          r_addr  <= r_addr + AW'(1);
          r_count <= r_count + CW'(1);
          if (w_col_wrap) begin
            r_col <= '0;
            r_row <= r_row + SW'(1);
          end else begin
            r_col <= r_col + SW'(1);
          end
        end
        if (w_last)                     r_done    <= 1'b1;
        if (bus.in_valid && !w_ready)   r_overrun <= 1'b1;
      end
    end
  end

  // Map storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_addr] <= bus.in_pixel;
  end

  // Read-before-write: a same-cycle write is seen on the following read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rd_data <= '0;
    else        r_rd_data <= r_mem[bus.rd_addr];
  end

  assign bus.in_ready = w_ready;
  assign bus.busy     = (r_state == S_COLLECT);
  assign bus.rd_data  = r_rd_data;
  assign bus.out_size = r_out_size;
  assign bus.count    = r_count;
  assign bus.done     = r_done;
  assign bus.cfg_err  = r_cfg_err;
  assign bus.overrun  = r_overrun;
endmodule

// File: tb/tb_conv_map_writer.sv
// Directed and randomized checks of conv_map_writer against a per-beat
// reference model of the map-collection rules.
module tb_conv_map_writer;
  localparam int unsigned MAX_N = 32;
  localparam int unsigned DEPTH = MAX_N * MAX_N;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_map_writer_if #(.DATA_W(16), .AW(10)) bus ();
  conv_map_writer #(.MAX_N(MAX_N), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: a map is a flat array filled in arrival order.
  bit          m_collect;
  int unsigned m_out, m_count;
  bit          m_done, m_cfg, m_ovr;
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_rd_known;
  logic [15:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", 32'(bus.in_ready), 32'(m_collect));
    chk("busy",     32'(bus.busy),     32'(m_collect));
    chk("done",     32'(bus.done),     32'(m_done));
    chk("count",    32'(bus.count),    m_count);
    chk("out_size", 32'(bus.out_size), m_out);
    chk("cfg_err",  32'(bus.cfg_err),  32'(m_cfg));
    chk("overrun",  32'(bus.overrun),  32'(m_ovr));
    if (m_rd_known) chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
  endtask

  task automatic model_reset();
    m_collect  = 1'b0;
    m_out      = 0;
    m_count    = 0;
    m_done     = 1'b0;
    m_cfg      = 1'b0;
    m_ovr      = 1'b0;
    m_rd_known = 1'b1;
    m_rd       = 16'd0;
  endtask

  task automatic cycle(input logic st, input logic [15:0] img, input logic [15:0] filt,
                       input logic v, input logic [15:0] pix, input logic [9:0] ra);
    bit          legal;
    bit          ready;
    logic [15:0] sz;
    @(negedge clk);
    bus.start      = st;
    bus.imgSize    = img;
    bus.filterSize = filt;
    bus.in_valid   = v;
    bus.in_pixel   = pix;
    bus.rd_addr    = ra;
    ready      = m_collect;
    m_rd_known = m_known[ra];
    m_rd       = m_mem[ra];
    m_done     = 1'b0;
    if (st) begin
      legal   = (filt == 16'd1 || filt == 16'd3 || filt == 16'd5) &&
                (img <= 16'(MAX_N)) && (img >= filt);
      sz      = img - 16'((filt / 16'd2) * 16'd2);
      m_out   = 32'(sz);
      m_count = 0;
      m_ovr   = 1'b0;
      m_cfg   = !legal;
      m_collect = legal;
      m_done  = !legal;
    end else if (v && ready) begin
      m_mem[m_count]   = pix;
      m_known[m_count] = 1'b1;
      m_count++;
      if (m_count == m_out * m_out) begin
        m_collect = 1'b0;
        m_done    = 1'b1;
      end
    end else if (v) begin
      m_ovr = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycle(input logic v, input logic [9:0] ra);
    cycle(1'b0, 16'd0, 16'd0, v, 16'($urandom), ra);
  endtask

  task automatic start_map(input logic [15:0] img, input logic [15:0] filt);
    cycle(1'b1, img, filt, 1'b0, 16'd0, 10'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
  endtask

  task automatic rand_cfg(output logic [15:0] img, output logic [15:0] filt);
    case ($urandom_range(0, 5))
      0: filt = 16'd1;
      1: filt = 16'd3;
      2: filt = 16'd5;
      3: filt = 16'd3;
      4: filt = 16'd4;
      default: filt = 16'd2;
    endcase
    img = ($urandom_range(0, 9) == 0) ? 16'd33 : 16'($urandom_range(0, 14));
  endtask

  initial begin
    logic [15:0] img, filt;
    for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 1'b0;
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.imgSize    = 16'd0;
    bus.filterSize = 16'd0;
    bus.in_valid   = 1'b0;
    bus.in_pixel   = 16'd0;
    bus.rd_addr    = 10'd0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    reset = 1'b1;

    // 5x5 image, 3x3 filter: nine contiguous beats
    start_map(16'd5, 16'd3);
    chk("t1_out_size", 32'(bus.out_size), 32'd3);
    for (int i = 1; i <= 9; i++) cycle(1'b0, 16'd0, 16'd0, 1'b1, 16'(i), 10'(i - 1));
    chk("t1_done", 32'(bus.done), 32'd1);
    idle_cycle(1'b0, 10'd4);
    chk("t1_rd4", 32'(bus.rd_data), 32'd5);

    // two beats after done -> overrun, map intact; start clears overrun
    idle_cycle(1'b1, 10'd0);
    idle_cycle(1'b1, 10'd1);
    chk("t3_overrun", 32'(bus.overrun), 32'd1);
    for (int i = 0; i < 9; i++) idle_cycle(1'b0, 10'(i));

    // same config with gaps in in_valid
    start_map(16'd5, 16'd3);
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b0, 16'd0, 16'd0, 1'b1, 16'(16'd200 + 16'(i)), 10'd0);
      if (i != 9) idle_cycle(1'b0, 10'(i));
    end
    for (int i = 0; i < 10; i++) idle_cycle(1'b0, 10'(i));

    // illegal configurations
    start_map(16'd5, 16'd4);
    chk("t4_cfg_err", 32'(bus.cfg_err), 32'd1);
    for (int i = 0; i < 3; i++) idle_cycle(1'b1, 10'(i));
    start_map(16'd33, 16'd3);
    idle_cycle(1'b1, 10'd0);
    start_map(16'd2, 16'd3);
    idle_cycle(1'b0, 10'd0);

    // full 32x32 map, then reset partway through the next one
    start_map(16'd32, 16'd1);
    for (int i = 0; i < 1024; i++) cycle(1'b0, 16'd0, 16'd0, 1'b1, 16'(i), 10'(1023 - i));
    chk("t5_count", 32'(bus.count), 32'd1024);
    idle_cycle(1'b0, 10'd1023);
    chk("t5_rd1023", 32'(bus.rd_data), 32'd1023);
    start_map(16'd32, 16'd1);
    for (int i = 0; i < 100; i++) cycle(1'b0, 16'd0, 16'd0, 1'b1, 16'(16'd5000 + 16'(i)), 10'(i));
    apply_reset();
    for (int i = 0; i < 4; i++) idle_cycle(1'(i % 2), 10'(i + 100));

    // restart mid-map at beat 4
    start_map(16'd5, 16'd3);
    for (int i = 1; i <= 3; i++) cycle(1'b0, 16'd0, 16'd0, 1'b1, 16'(i), 10'd0);
    cycle(1'b1, 16'd5, 16'd3, 1'b1, 16'd77, 10'd0);
    for (int i = 1; i <= 9; i++) cycle(1'b0, 16'd0, 16'd0, 1'b1, 16'(16'd100 + 16'(i)), 10'd0);
    for (int i = 0; i < 10; i++) idle_cycle(1'b0, 10'(i));

    // randomized maps with random gaps, reads and occasional restarts
    for (int m = 0; m < 12; m++) begin
      rand_cfg(img, filt);
      start_map(img, filt);
      for (int c = 0; c < 260; c++) begin
        if ($urandom_range(0, 199) == 0) begin
          rand_cfg(img, filt);
          cycle(1'b1, img, filt, 1'($urandom_range(0, 1)), 16'($urandom), 10'($urandom));
        end else begin
          cycle(1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 9) < 7),
                16'($urandom), 10'($urandom_range(0, 255)));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
